msg_frame_parser: RTL and testbench
===================================

Name: msg_frame_parser

Overview:
- Downstream consumer of the message link receive byte stream (rd_data_vld/rd_data from the message_comm receive path). Runs on the same clock domain.
- Locates framed messages and checks the length and the 8-bit checksum.
- Presents the command ID, the length and streamed payload bytes to the command-decode logic.
- Flags malformed or stalled frames and keeps saturating statistics.

Parameters:
- HDR0, 8'h55, first header byte
- HDR1, 8'hAA, second header byte
- MAX_LEN, 1024, largest legal payload length in bytes
- TIMEOUT_CYC, 4096, maximum number of idle cycles between bytes inside a frame

Ports:
- clk  in  1  system clock (the phy_rx_clk domain of the receive path)
- rst_n  in  1  asynchronous active-low reset
- rd_data_vld_i  in  1  input byte strobe, one byte per asserted cycle, no backpressure
- rd_data_i  in  8  input byte
- cmd_start_o  out  1  one-cycle pulse: header, command and length accepted
- cmd_id_o  out  16  command ID, held from cmd_start_o until the next cmd_start_o
- cmd_len_o  out  16  payload length, held the same way as cmd_id_o
- pld_vld_o  out  1  payload byte strobe
- pld_data_o  out  8  payload byte
- pld_last_o  out  1  marks the final payload byte, qualified by pld_vld_o
- frame_ok_o  out  1  one-cycle pulse: checksum matched
- frame_err_o  out  1  one-cycle pulse: frame aborted
- err_code_o  out  2  error cause, valid with frame_err_o and held afterwards: 1=checksum, 2=length, 3=timeout
- frame_cnt_o  out  16  good-frame count, saturates at 16'hFFFF
- err_cnt_o  out  16  error count, saturates at 16'hFFFF

Behaviour:
- Reset: every output is 0. The state machine goes to IDLE. Counters, checksum and timeout counter clear.
- Frame format: HDR0, HDR1, CMD_H, CMD_L, LEN_H, LEN_L, LEN payload bytes, SUM.
  - SUM is the 8-bit modulo-256 sum of CMD_H through the last payload byte. The header bytes are excluded.
- States and transitions (advance only on rd_data_vld_i):
  - IDLE: byte==HDR0 -> HEAD.
  - HEAD: byte==HDR1 -> CMDH. byte==HDR0 -> stay in HEAD (resync). Any other byte -> IDLE, with no error pulse.
  - CMDH -> CMDL -> LENH -> LENL.
  - LENL: LEN>MAX_LEN -> frame_err_o with code 2, then IDLE. LEN==0 -> SUM. Otherwise -> PLD.
  - PLD: count payload bytes. After byte number LEN -> SUM.
  - SUM: received byte equals the accumulator -> frame_ok_o. Mismatch -> frame_err_o with code 1. Both cases -> IDLE.
- Latency: every output is registered and appears 1 cycle after the accepting rd_data_vld_i cycle.
  - cmd_start_o fires on the cycle after LEN_L, whether LEN is 0 or nonzero. It does not fire when LEN>MAX_LEN.
  - pld_data_o is the input byte delayed by one cycle. pld_last_o is high with byte number LEN.
- Checksum accumulator: clears on entry to CMDH, then adds every byte from CMD_H through the payload. Width 8 bits, wraps.
- Payload counter: 16 bits, compared against the latched LEN. No wrap is possible because LEN≤MAX_LEN.
- Timeout counter:
  - Clears on each rd_data_vld_i.
  - Increments in every state except IDLE.
  - When it reaches TIMEOUT_CYC with no strobe that cycle: frame_err_o with code 3, then IDLE.
  - If a strobe arrives on the terminal cycle, the strobe wins and no timeout is raised.
  - Does not run in IDLE or in the HEAD-resync sense. The HEAD state does time out, with code 3.
- Statistics:
  - frame_cnt_o increments on each frame_ok_o.
  - err_cnt_o increments on each frame_err_o.
  - Both hold at 16'hFFFF.
- frame_ok_o and frame_err_o are mutually exclusive. At most one frame event occurs per cycle.
- Back-to-back frames: a HDR0 arriving on the cycle right after SUM is accepted normally. There are no dead cycles.
- Asynchronous reset mid-frame: immediate IDLE, with no error pulse and no count change.
- Bytes arriving in IDLE that do not match HDR0 are silently dropped.

Test Plan:
- Good frame: 55 AA 01 02 00 03 10 20 30 SUM=0x66 -> cmd_start_o with cmd_id_o=16'h0102 and cmd_len_o=3; pld bytes 10, 20, 30 with pld_last_o on 30; frame_ok_o; frame_cnt_o=1.
- Zero length: 55 AA 00 07 00 00 07 -> cmd_start_o with len=0; no pld_vld_o; frame_ok_o.
- Bad checksum: the good frame with SUM=0x67 -> frame_err_o with err_code_o=1; err_cnt_o=1; frame_cnt_o unchanged.
- Length error: 55 AA 00 01 04 01 (LEN=1025) -> frame_err_o with code 2 one cycle after LEN_L; no cmd_start_o; the next valid frame parses correctly.
- Timeout and resync: 55 AA 01, then no strobe for 4096 cycles -> frame_err_o with code 3. Then 55 55 AA 00 01 00 00 01 -> frame_ok_o. A repeat run with the strobe landing exactly on cycle 4096 -> no timeout.
- Saturation and reset: preload 65535 good frames, then send one more -> frame_cnt_o stays 16'hFFFF. Assert rst_n low mid-payload -> all outputs 0 and no error pulse.

Source files
------------

// File: rtl/msg_frame_parser.sv
// Message frame parser: finds HDR0/HDR1 framed messages on the receive
// byte stream, checks length and checksum, streams payload, keeps stats.
module msg_frame_parser #(
    parameter logic [7:0] HDR0        = 8'h55,
    parameter logic [7:0] HDR1        = 8'hAA,
    parameter int         MAX_LEN     = 1024,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_data_vld_i,
    input  logic [7:0]  rd_data_i,
    output logic        cmd_start_o,
    output logic [15:0] cmd_id_o,
    output logic [15:0] cmd_len_o,
    output logic        pld_vld_o,
    output logic [7:0]  pld_data_o,
    output logic        pld_last_o,
    output logic        frame_ok_o,
    output logic        frame_err_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] err_cnt_o
);

    localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    localparam logic [1:0] ERR_SUM = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        CMDH,
        CMDL,
        LENH,
        LENL,
        PLD,
        SUM
    } state_t;

    state_t        state_q;
    logic [7:0]    cmd_h_q;
    logic [7:0]    cmd_l_q;
    logic [7:0]    len_h_q;
    logic [7:0]    sum_q;
    logic [15:0]   pld_cnt_q;
    logic [TW-1:0] tmo_q;

    logic [15:0] len_in;
    logic [15:0] pld_cnt_nxt;

    assign len_in      = {len_h_q, rd_data_i};
    assign pld_cnt_nxt = pld_cnt_q + 16'd1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Frame state machine with registered outputs, checksum, timeout and stats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_h_q     <= '0;
            cmd_l_q     <= '0;
            len_h_q     <= '0;
            sum_q       <= '0;
            pld_cnt_q   <= '0;
            tmo_q       <= '0;
            cmd_start_o <= 1'b0;
            cmd_id_o    <= '0;
            cmd_len_o   <= '0;
            pld_vld_o   <= 1'b0;
            pld_data_o  <= '0;
            pld_last_o  <= 1'b0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            err_code_o  <= '0;
            frame_cnt_o <= '0;
            err_cnt_o   <= '0;
        end else begin
            cmd_start_o <= 1'b0;
            pld_vld_o   <= 1'b0;
            pld_last_o  <= 1'b0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            if (rd_data_vld_i) begin
                tmo_q <= '0;
                unique case (state_q)
                    IDLE: begin
                        if (rd_data_i == HDR0)
                            state_q <= HEAD;
                    end
                    HEAD: begin
                        if (rd_data_i == HDR1) begin
                            state_q <= CMDH;
                            sum_q   <= '0;
                        end else if (rd_data_i != HDR0) begin
                            state_q <= IDLE;
                        end
                    end
                    CMDH: begin
                        cmd_h_q <= rd_data_i;
                        sum_q   <= sum_q + rd_data_i;
                        state_q <= CMDL;
                    end
                    CMDL: begin
                        cmd_l_q <= rd_data_i;
                        sum_q   <= sum_q + rd_data_i;
                        state_q <= LENH;
                    end
                    LENH: begin
                        len_h_q <= rd_data_i;
                        sum_q   <= sum_q + rd_data_i;
                        state_q <= LENL;
                    end
                    LENL: begin
                        sum_q     <= sum_q + rd_data_i;
                        pld_cnt_q <= '0;
                        if (len_in > MAX_LEN_W) begin
                            frame_err_o <= 1'b1;
                            err_code_o  <= ERR_LEN;
                            err_cnt_o   <= sat_inc(err_cnt_o);
                            state_q     <= IDLE;
                        end else begin
                            cmd_start_o <= 1'b1;
                            cmd_id_o    <= {cmd_h_q, cmd_l_q};
                            cmd_len_o   <= len_in;
                            state_q     <= (len_in == 16'd0) ? SUM : PLD;
                        end
                    end
                    PLD: begin
                        sum_q      <= sum_q + rd_data_i;
                        pld_vld_o  <= 1'b1;
                        pld_data_o <= rd_data_i;
                        pld_cnt_q  <= pld_cnt_nxt;
                        if (pld_cnt_nxt == cmd_len_o) begin
                            pld_last_o <= 1'b1;
                            state_q    <= SUM;
                        end
                    end
                    SUM: begin
                        if (rd_data_i == sum_q) begin
                            frame_ok_o  <= 1'b1;
                            frame_cnt_o <= sat_inc(frame_cnt_o);
                        end else begin
                            frame_err_o <= 1'b1;
                            err_code_o  <= ERR_SUM;
                            err_cnt_o   <= sat_inc(err_cnt_o);
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (tmo_q == TMO_END) begin
                    frame_err_o <= 1'b1;
                    err_code_o  <= ERR_TMO;
                    err_cnt_o   <= sat_inc(err_cnt_o);
                    tmo_q       <= '0;
                    state_q     <= IDLE;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_msg_frame_parser.sv
// Bench for msg_frame_parser: table of frames plus timeout, saturation
// and reset sequences, checked through an expected-event scoreboard.
module tb_msg_frame_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_data_vld_i = 1'b0;
    logic [7:0]  rd_data_i = 8'h00;
    logic        cmd_start_o;
    logic [15:0] cmd_id_o;
    logic [15:0] cmd_len_o;
    logic        pld_vld_o;
    logic [7:0]  pld_data_o;
    logic        pld_last_o;
    logic        frame_ok_o;
    logic        frame_err_o;
    logic [1:0]  err_code_o;
    logic [15:0] frame_cnt_o;
    logic [15:0] err_cnt_o;

    always #5 clk = ~clk;

    msg_frame_parser dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_data_vld_i(rd_data_vld_i),
        .rd_data_i    (rd_data_i),
        .cmd_start_o  (cmd_start_o),
        .cmd_id_o     (cmd_id_o),
        .cmd_len_o    (cmd_len_o),
        .pld_vld_o    (pld_vld_o),
        .pld_data_o   (pld_data_o),
        .pld_last_o   (pld_last_o),
        .frame_ok_o   (frame_ok_o),
        .frame_err_o  (frame_err_o),
        .err_code_o   (err_code_o),
        .frame_cnt_o  (frame_cnt_o),
        .err_cnt_o    (err_cnt_o)
    );

    // kind: 0=cmd_start(a=id,b=len) 1=payload(a=data,b=last) 2=ok 3=err(a=code)
    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] len;
        logic [7:0]  seed;
        logic [7:0]  step;
        logic [7:0]  sx;
        logic        start;
        logic [1:0]  code;
        logic        gap;
        logic        b2b;
    } vec_t;

    ev_t         expq[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_frames = 16'd0;
    logic [15:0] exp_errs = 16'd0;
    logic [15:0] last_id = 16'd0;
    logic [15:0] last_len = 16'd0;
    vec_t        tbl[11];

    function automatic ev_t mk(input logic [1:0] k, input logic [15:0] a,
                               input logic [15:0] b);
        ev_t e;
        e.kind = k;
        e.a = a;
        e.b = b;
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic obs(input ev_t e);
        ev_t x;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %0h expected none", e);
        end else begin
            x = expq.pop_front();
            check("event", e, x);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_ok_o && frame_err_o) begin
                checks++;
                errors++;
                $display("FAIL ok_err_excl: got both expected one");
            end
            if (cmd_start_o) obs(mk(2'd0, cmd_id_o, cmd_len_o));
            if (pld_vld_o) obs(mk(2'd1, {8'h00, pld_data_o}, {15'd0, pld_last_o}));
            if (frame_ok_o) obs(mk(2'd2, 16'd0, 16'd0));
            if (frame_err_o) obs(mk(2'd3, {14'd0, err_code_o}, 16'd0));
        end
    end

    task automatic drive(input logic v, input logic [7:0] b);
        rd_data_vld_i = v;
        rd_data_i = b;
        @(negedge clk);
        rd_data_vld_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic put(input logic [7:0] b, input logic gap);
        if (gap) idle($urandom_range(0, 3));
        drive(1'b1, b);
    endtask

    task automatic bump_ok();
        if (exp_frames != 16'hFFFF) exp_frames++;
    endtask

    task automatic bump_err();
        if (exp_errs != 16'hFFFF) exp_errs++;
    endtask

    task automatic send_vec(input vec_t v);
        logic [7:0] s;
        logic [7:0] p;
        p = v.seed;
        if (v.start) begin
            expq.push_back(mk(2'd0, v.cmd, v.len));
            last_id = v.cmd;
            last_len = v.len;
            for (int i = 0; i < int'(v.len); i++) begin
                expq.push_back(mk(2'd1, {8'h00, p},
                                  (i == int'(v.len) - 1) ? 16'd1 : 16'd0));
                p = p + v.step;
            end
        end
        if (v.code == 2'd0) begin
            expq.push_back(mk(2'd2, 16'd0, 16'd0));
            bump_ok();
        end else begin
            expq.push_back(mk(2'd3, {14'd0, v.code}, 16'd0));
            bump_err();
        end
        put(8'h55, v.gap);
        put(8'hAA, v.gap);
        put(v.cmd[15:8], v.gap);
        put(v.cmd[7:0], v.gap);
        put(v.len[15:8], v.gap);
        put(v.len[7:0], v.gap);
        if (v.code != 2'd2) begin
            s = v.cmd[15:8] + v.cmd[7:0] + v.len[15:8] + v.len[7:0];
            p = v.seed;
            for (int i = 0; i < int'(v.len); i++) begin
                put(p, v.gap);
                s = s + p;
                p = p + v.step;
            end
            put(s ^ v.sx, v.gap);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (2) @(negedge clk);
        #1;
        check("drain", expq.size(), 0);
        check("frame_cnt", frame_cnt_o, exp_frames);
        check("err_cnt", err_cnt_o, exp_errs);
        check("cmd_id_hold", cmd_id_o, last_id);
        check("cmd_len_hold", cmd_len_o, last_len);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // cmd, len, seed, step, sum xor, start, code, gaps, back-to-back
        tbl[0]  = '{16'h0102, 16'd3,    8'h10, 8'h10, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{16'h0007, 16'd0,    8'h00, 8'h00, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{16'h0102, 16'd3,    8'h10, 8'h10, 8'h01, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[3]  = '{16'h0001, 16'h0401, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[4]  = '{16'h0102, 16'd3,    8'h10, 8'h10, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{16'hABCD, 16'd1024, 8'h00, 8'h01, 8'h00, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{16'hFFFF, 16'd1,    8'hFF, 8'h00, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1};
        tbl[7]  = '{16'h1234, 16'd5,    8'h03, 8'h07, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1};
        tbl[8]  = '{16'h4321, 16'd20,   8'h80, 8'h13, 8'h80, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[9]  = '{16'h0000, 16'hFFFF, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[10] = '{16'h0000, 16'd1,    8'h55, 8'h00, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0};

        #2;
        check("reset_outputs",
              {cmd_start_o, cmd_id_o, cmd_len_o, pld_vld_o, pld_data_o,
               pld_last_o, frame_ok_o, frame_err_o, err_code_o,
               frame_cnt_o, err_cnt_o}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Noise in IDLE and a broken header are dropped silently
        drive(1'b1, 8'h12);
        drive(1'b1, 8'hAA);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h13);
        drive(1'b1, 8'h34);
        drain();

        for (int i = 0; i < 11; i++) begin
            send_vec(tbl[i]);
            if (!tbl[i].b2b) drain();
        end

        // Timeout in CMDL after 55 AA 01
        expq.push_back(mk(2'd3, 16'd3, 16'd0));
        bump_err();
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        drive(1'b1, 8'h01);
        idle(4095);
        #1;
        check("tmo_early", expq.size(), 1);
        idle(1);
        #1;
        check("tmo_fire", expq.size(), 0);
        drain();

        // Resync on repeated HDR0, strobe on the terminal cycle wins
        expq.push_back(mk(2'd0, 16'h0001, 16'd0));
        expq.push_back(mk(2'd2, 16'd0, 16'd0));
        last_id = 16'h0001;
        last_len = 16'd0;
        bump_ok();
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h00);
        idle(4095);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h01);
        drain();

        // HEAD state also times out
        expq.push_back(mk(2'd3, 16'd3, 16'd0));
        bump_err();
        drive(1'b1, 8'h55);
        idle(4096);
        drain();

        // Frame counter saturation
        force dut.frame_cnt_o = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt_o;
        exp_frames = 16'hFFFE;
        idle(1);
        #1;
        check("preload_frames", frame_cnt_o, exp_frames);
        send_vec(tbl[0]);
        drain();
        send_vec(tbl[0]);
        drain();

        // Error counter saturation
        force dut.err_cnt_o = 16'hFFFF;
        @(negedge clk);
        release dut.err_cnt_o;
        exp_errs = 16'hFFFF;
        send_vec(tbl[2]);
        drain();

        // Reset in the middle of the payload
        expq.push_back(mk(2'd0, 16'h0909, 16'd5));
        expq.push_back(mk(2'd1, 16'h00A1, 16'd0));
        expq.push_back(mk(2'd1, 16'h00A2, 16'd0));
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        drive(1'b1, 8'h09);
        drive(1'b1, 8'h09);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h05);
        drive(1'b1, 8'hA1);
        drive(1'b1, 8'hA2);
        #2;
        check("pre_reset_events", expq.size(), 0);
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs",
              {cmd_start_o, cmd_id_o, cmd_len_o, pld_vld_o, pld_data_o,
               pld_last_o, frame_ok_o, frame_err_o, err_code_o,
               frame_cnt_o, err_cnt_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 16'd0;
        exp_errs = 16'd0;
        last_id = 16'd0;
        last_len = 16'd0;
        idle(20);
        drain();
        send_vec(tbl[0]);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
